// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_pkg
//
// Shared definitions for the ALU issue stage and its register file:
//   - datapath / register-index / opsel widths
//   - the main_alu operation encoding (opsel values travel through the issue
//     stage untouched, but the bench and main_alu agree on them here)
//   - a small helper that tests one source operand against an in-flight
//     destination register
// ---------------------------------------------------------------------------
package alu_issue_stage_pkg;

   localparam int RV_XLEN    = 32;
   localparam int NREG_DEF   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int OPSEL_W    = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [OPSEL_W-1:0]    opsel_t;

   typedef enum logic [OPSEL_W-1:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLL  = 4'h5,
      ALU_SRL  = 4'h6,
      ALU_SRA  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9
   } alu_op_e;

   // True when a used, non-zero source register matches a valid in-flight
   // destination. x0 never creates a dependency since it always reads zero.
   function automatic logic src_hit(input logic      used,
                                    input reg_addr_t rs,
                                    input logic      vld,
                                    input reg_addr_t rd);
      return used && (rs != '0) && vld && (rs == rd);
   endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_regfile
//
// Architectural integer register file for the ALU issue stage.
//   - two combinational read ports; index 0 always reads zero
//   - one synchronous write port; writes to index 0 are discarded
//   - asynchronous active-high reset clears every entry
// No write-through path: the issue stage's forwarding mux already supplies
// the value being written when a read and a write hit the same index.
//
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_raddr1 / o_rdata1       read port 1
//   i_raddr2 / o_rdata2       read port 2
//   i_we, i_waddr, i_wdata    write port
// ---------------------------------------------------------------------------
module alu_issue_stage_regfile
   import alu_issue_stage_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int NREG = NREG_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  reg_addr_t       i_raddr1,
   output logic [XLEN-1:0] o_rdata1,
   input  reg_addr_t       i_raddr2,
   output logic [XLEN-1:0] o_rdata2,
   input  logic            i_we,
   input  reg_addr_t       i_waddr,
   input  logic [XLEN-1:0] i_wdata
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == '0) ? '0 : regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? '0 : regs[i_raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage in front of main_alu. Accepts one decoded ALU instruction per
// cycle over a valid/ready handshake, reads its sources from the internal
// register file (or takes the result currently leaving main_alu), registers
// op1/op2/opsel into main_alu, follows the instruction through the ALU's
// one-cycle latency, writes the result back and reports it on a retire port.
//
// Pipeline positions:
//   E1 : operand registers o_op1/o_op2/o_opsel + vld_p1/rd_p1
//   E2 : vld_p2/rd_p2, aligned with i_aluout
//   retire : o_ret_valid/o_ret_rd/o_ret_data, one cycle after writeback
//
// Ports:
//   i_clk, i_rst                   clock, async active-high reset
//   i_valid / o_ready              instruction handshake (o_ready = !hazard)
//   i_rs1, i_rs2, i_rd             register indices
//   i_imm, i_pc                    immediate and PC operand candidates
//   i_use_imm, i_use_pc            operand selects (op2 = imm, op1 = pc)
//   i_opsel                        ALU operation, passed through
//   o_op1, o_op2, o_opsel          registered operands to main_alu
//   i_aluout                       main_alu result (valid while E2 is valid)
//   o_ret_valid, o_ret_rd, o_ret_data  retire report
// ---------------------------------------------------------------------------
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int NREG = NREG_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [REG_ADDR_W-1:0] i_rs1,
   input  logic [REG_ADDR_W-1:0] i_rs2,
   input  logic [REG_ADDR_W-1:0] i_rd,
   input  logic [XLEN-1:0]       i_imm,
   input  logic [XLEN-1:0]       i_pc,
   input  logic                  i_use_imm,
   input  logic                  i_use_pc,
   input  logic [OPSEL_W-1:0]    i_opsel,
   output logic [XLEN-1:0]       o_op1,
   output logic [XLEN-1:0]       o_op2,
   output logic [OPSEL_W-1:0]    o_opsel,
   input  logic [XLEN-1:0]       i_aluout,
   output logic                  o_ret_valid,
   output logic [REG_ADDR_W-1:0] o_ret_rd,
   output logic [XLEN-1:0]       o_ret_data
);

   // Source operand value: x0 is zero, the result leaving main_alu wins over
   // the register file (this also covers a same-cycle write and read of one
   // index), otherwise the register file. A match on rd 0 cannot occur here
   // because rs 0 has already been filtered out.
   function automatic logic [XLEN-1:0] pick_src(input reg_addr_t       rs,
                                                input logic [XLEN-1:0] rf_data,
                                                input logic            fwd_vld,
                                                input reg_addr_t       fwd_rd,
                                                input logic [XLEN-1:0] fwd_data);
      if (rs == '0) begin
         return '0;
      end
      if (fwd_vld && (rs == fwd_rd)) begin
         return fwd_data;
      end
      return rf_data;
   endfunction

   logic            vld_p1;
   reg_addr_t       rd_p1;
   logic            vld_p2;
   reg_addr_t       rd_p2;

   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;
   logic            wb_we;

   logic            haz_rs1;
   logic            haz_rs2;
   logic            xfer;
   logic [XLEN-1:0] op1_nxt;
   logic [XLEN-1:0] op2_nxt;

   alu_issue_stage_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raddr1 (i_rs1),
      .o_rdata1 (rf_rdata1),
      .i_raddr2 (i_rs2),
      .o_rdata2 (rf_rdata2),
      .i_we     (wb_we),
      .i_waddr  (rd_p2),
      .i_wdata  (i_aluout)
   );

   // The only stall source is a producer sitting in E1: its result does not
   // exist yet. A producer in E2 is covered by forwarding i_aluout. Sources
   // replaced by pc/imm are not read, so they never stall.
   assign haz_rs1 = src_hit(!i_use_pc,  i_rs1, vld_p1, rd_p1);
   assign haz_rs2 = src_hit(!i_use_imm, i_rs2, vld_p1, rd_p1);
   assign o_ready = !(haz_rs1 || haz_rs2);
   assign xfer    = i_valid && o_ready;

   always_comb begin
      op1_nxt = i_use_pc  ? i_pc
                          : pick_src(i_rs1, rf_rdata1, vld_p2, rd_p2, i_aluout);
      op2_nxt = i_use_imm ? i_imm
                          : pick_src(i_rs2, rf_rdata2, vld_p2, rd_p2, i_aluout);
   end

   // Writes to x0 are dropped here (and again inside the register file);
   // the instruction still retires.
   assign wb_we = vld_p2 && (rd_p2 != '0);

   // ---- issue -> E1 : operand registers feeding main_alu --------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_p1  <= 1'b0;
         rd_p1   <= '0;
         o_op1   <= '0;
         o_op2   <= '0;
         o_opsel <= '0;
      end else begin
         vld_p1 <= xfer;
         if (xfer) begin
            rd_p1   <= i_rd;
            o_op1   <= op1_nxt;
            o_op2   <= op2_nxt;
            o_opsel <= i_opsel;
         end
      end
   end

   // ---- E1 -> E2 : main_alu result becomes valid ----------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_p2 <= 1'b0;
         rd_p2  <= '0;
      end else begin
         vld_p2 <= vld_p1;
         rd_p2  <= rd_p1;
      end
   end

   // ---- E2 -> retire : writeback edge, report follows ------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ret_valid <= 1'b0;
         o_ret_rd    <= '0;
         o_ret_data  <= '0;
      end else begin
         o_ret_valid <= vld_p2;
         if (vld_p2) begin
            o_ret_rd   <= rd_p2;
            o_ret_data <= i_aluout;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Bench for alu_issue_stage. A one-cycle main_alu model drives i_aluout.
// A reference model keeps the architectural register state and evaluates
// every accepted instruction in program order; it predicts o_ready, the
// operands presented to main_alu and the in-order retire stream. Directed
// table vectors and hand-written sequences cover the corner cases, then a
// randomized run exercises hazards and forwarding.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0;
   logic [31:0] i_imm = '0, i_pc = '0;
   logic        i_use_imm = 1'b0, i_use_pc = 1'b0;
   logic [3:0]  i_opsel = '0;
   logic [31:0] o_op1, o_op2;
   logic [3:0]  o_opsel;
   logic [31:0] i_aluout = '0;
   logic        o_ret_valid;
   logic [4:0]  o_ret_rd;
   logic [31:0] o_ret_data;

   alu_issue_stage dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .i_rd        (i_rd),
      .i_imm       (i_imm),
      .i_pc        (i_pc),
      .i_use_imm   (i_use_imm),
      .i_use_pc    (i_use_pc),
      .i_opsel     (i_opsel),
      .o_op1       (o_op1),
      .o_op2       (o_op2),
      .o_opsel     (o_opsel),
      .i_aluout    (i_aluout),
      .o_ret_valid (o_ret_valid),
      .o_ret_rd    (o_ret_rd),
      .o_ret_data  (o_ret_data)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
      case (s)
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return a + b;
      endcase
   endfunction

   // main_alu: result appears the cycle after the operands are presented
   always @(posedge i_clk) i_aluout <= alu_f(o_op1, o_op2, o_opsel);

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model (sampled on the falling edge)
   // ------------------------------------------------------------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ret_t;

   logic [31:0] arch [32];
   ret_t        exp_q[$];
   int          ret_cycles[$];
   int          cyc = 0;
   bit          prev_xfer = 0;
   logic [4:0]  prev_rd = '0;
   logic [31:0] prev_op1 = '0, prev_op2 = '0;
   logic [3:0]  prev_sel = '0;

   initial begin
      bit          hz, xf;
      logic [31:0] a, b, res;
      ret_t        r_exp;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (i_rst) begin
            for (int r = 0; r < 32; r++) arch[r] = '0;
            exp_q.delete();
            prev_xfer = 0;
         end else begin
            if (o_ret_valid) begin
               ret_cycles.push_back(cyc);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL ret_unexpected: rd %0d data 0x%08h, required no retire",
                           o_ret_rd, o_ret_data);
               end else begin
                  r_exp = exp_q.pop_front();
                  chk("ret_rd", 32'(o_ret_rd), 32'(r_exp.rd));
                  chk("ret_data", o_ret_data, r_exp.data);
               end
            end
            if (prev_xfer) begin
               chk("op1", o_op1, prev_op1);
               chk("op2", o_op2, prev_op2);
               chk("opsel", 32'(o_opsel), 32'(prev_sel));
            end
            // an instruction accepted last cycle has no result yet
            hz = prev_xfer && (prev_rd != 0) &&
                 ((!i_use_pc && i_rs1 == prev_rd) || (!i_use_imm && i_rs2 == prev_rd));
            chk("ready", 32'(o_ready), 32'(!hz));
            xf = i_valid && !hz;
            if (xf) begin
               a   = i_use_pc  ? i_pc  : arch[i_rs1];
               b   = i_use_imm ? i_imm : arch[i_rs2];
               res = alu_f(a, b, i_opsel);
               if (i_rd != 0) arch[i_rd] = res;
               exp_q.push_back('{rd: i_rd, data: res});
               prev_op1 = a;
               prev_op2 = b;
               prev_sel = i_opsel;
               prev_rd  = i_rd;
            end
            prev_xfer = xf;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm, pc;
      logic        use_imm, use_pc;
      logic [3:0]  opsel;
   } instr_t;

   typedef struct {
      instr_t      ins;
      int          stall;
      logic [31:0] op1;
      logic [31:0] op2;
   } vec_t;

   function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic use_imm,
                                 input logic use_pc, input logic [3:0] opsel);
      instr_t t;
      t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.imm = imm; t.pc = pc;
      t.use_imm = use_imm; t.use_pc = use_pc; t.opsel = opsel;
      return t;
   endfunction

   // Present one instruction (called just after a rising edge) and hold it
   // until accepted; returns the number of stall cycles seen.
   task automatic issue(input instr_t t, output int stalls);
      bit done;
      i_valid = 1'b1; i_rs1 = t.rs1; i_rs2 = t.rs2; i_rd = t.rd;
      i_imm = t.imm; i_pc = t.pc; i_use_imm = t.use_imm; i_use_pc = t.use_pc;
      i_opsel = t.opsel;
      stalls = 0;
      done = 0;
      while (!done) begin
         @(negedge i_clk);
         if (o_ready) begin
            done = 1;
         end else begin
            stalls++;
            if (stalls > 8) begin
               vectors++;
               miscompares++;
               $display("FAIL issue_timeout: o_ready low %0d cycles, required accept", stalls);
               done = 1;
            end
         end
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Main test
   // ------------------------------------------------------------------
   vec_t tbl[12];

   initial begin
      int st, rets, n;
      bit new_needed, taken;

      tbl[0]  = '{mk(0, 0, 0, 5, 0, 1, 0, ALU_ADD),       0, 32'd0,     32'd5};
      tbl[1]  = '{mk(0, 0, 1, 7, 0, 1, 0, ALU_ADD),       0, 32'd0,     32'd7};
      tbl[2]  = '{mk(0, 0, 1, 10, 0, 1, 0, ALU_ADD),      0, 32'd0,     32'd10};
      tbl[3]  = '{mk(1, 0, 2, 1, 0, 1, 0, ALU_ADD),       1, 32'd10,    32'd1};
      tbl[4]  = '{mk(0, 0, 1, 3, 0, 1, 0, ALU_ADD),       0, 32'd0,     32'd3};
      tbl[5]  = '{mk(0, 0, 5, 9, 0, 1, 0, ALU_ADD),       0, 32'd0,     32'd9};
      tbl[6]  = '{mk(1, 1, 3, 0, 0, 0, 0, ALU_ADD),       0, 32'd3,     32'd3};
      tbl[7]  = '{mk(3, 3, 4, 0, 0, 0, 0, ALU_ADD),       1, 32'd6,     32'd6};
      tbl[8]  = '{mk(4, 0, 6, 4, 32'h100, 1, 1, ALU_ADD), 0, 32'h100,   32'd4};
      tbl[9]  = '{mk(4, 3, 7, 0, 0, 0, 0, ALU_SUB),       0, 32'd12,    32'd6};
      tbl[10] = '{mk(0, 7, 8, 32'h55, 0, 1, 0, ALU_OR),   0, 32'd0,     32'h55};
      tbl[11] = '{mk(0, 8, 9, 0, 0, 0, 0, ALU_ADD),       1, 32'd0,     32'h55};

      // reset, then idle outputs
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_op1", o_op1, 32'd0);
      chk("rst_op2", o_op2, 32'd0);
      chk("rst_opsel", 32'(o_opsel), 32'd0);
      chk("rst_ret_valid", 32'(o_ret_valid), 32'd0);
      chk("rst_ret_rd", 32'(o_ret_rd), 32'd0);
      chk("rst_ret_data", o_ret_data, 32'd0);

      // directed vectors: x0, RAW stall, distance-2 forward, operand select
      for (int i = 0; i < 12; i++) begin
         issue(tbl[i].ins, st);
         chk($sformatf("tbl%0d_stall", i), st, tbl[i].stall);
         chk($sformatf("tbl%0d_op1", i), o_op1, tbl[i].op1);
         chk($sformatf("tbl%0d_op2", i), o_op2, tbl[i].op2);
      end

      // retire latency of a lone instruction
      repeat (5) @(posedge i_clk);
      #1;
      issue(mk(0, 0, 12, 32'h77, 0, 1, 0, ALU_ADD), st);
      for (int k = 1; k <= 4; k++) begin
         @(negedge i_clk);
         chk($sformatf("lat_ret_valid_%0d", k), 32'(o_ret_valid), (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) begin
            chk("lat_ret_rd", 32'(o_ret_rd), 32'd12);
            chk("lat_ret_data", o_ret_data, 32'h77);
         end
      end
      @(posedge i_clk);
      #1;

      // 16 independent ADDs at full rate
      ret_cycles.delete();
      for (int k = 0; k < 16; k++) begin
         issue(mk(0, 0, 5'(10 + k), 32'(k * 32'h101 + 1), 0, 1, 0, ALU_ADD), st);
         chk($sformatf("stream%0d_stall", k), st, 0);
      end
      repeat (6) @(negedge i_clk);
      chk("stream_count", ret_cycles.size(), 16);
      if (ret_cycles.size() > 0)
         chk("stream_span", ret_cycles[$] - ret_cycles[0], 15);
      @(posedge i_clk);
      #1;

      // reset with E1 and E2 both occupied: nothing may retire afterwards
      issue(mk(0, 0, 3, 32'h11, 0, 1, 0, ALU_ADD), st);
      issue(mk(0, 0, 4, 32'h22, 0, 1, 0, ALU_ADD), st);
      #2;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      rets = 0;
      repeat (5) begin
         @(negedge i_clk);
         if (o_ret_valid) rets++;
      end
      chk("midrst_no_retire", rets, 0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      @(posedge i_clk);
      #1;
      // x3/x4 held 6/12 before reset; the register file must now read zero
      issue(mk(3, 4, 5, 0, 0, 0, 0, ALU_ADD), st);
      chk("midrst_x3", o_op1, 32'd0);
      chk("midrst_x4", o_op2, 32'd0);

      // randomized stream against the reference model
      new_needed = 1;
      for (n = 0; n < 1500; n++) begin
         if (new_needed) begin
            i_valid   = ($urandom_range(0, 9) < 8);
            i_rs1     = 5'($urandom_range(0, 7));
            i_rs2     = 5'($urandom_range(0, 7));
            i_rd      = 5'($urandom_range(0, 7));
            i_use_imm = ($urandom_range(0, 2) == 0);
            i_use_pc  = ($urandom_range(0, 3) == 0);
            i_opsel   = 4'($urandom_range(0, 4));
            i_imm     = $urandom;
            i_pc      = $urandom;
         end
         @(negedge i_clk);
         taken = i_valid && o_ready;
         new_needed = taken || !i_valid;
         @(posedge i_clk);
         #1;
      end
      i_valid = 1'b0;
      repeat (6) @(posedge i_clk);
      @(negedge i_clk);
      chk("drain_outstanding", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue stage directly upstream of `main_alu` in the funRV32 datapath. It accepts decoded ALU instructions over a valid/ready handshake and reads source operands from an internal 32×32 register file, forwarding the in-flight ALU result where needed. It registers `op1`/`op2`/`opsel` into `main_alu` and tracks each instruction through the ALU's one-cycle latency. It writes the ALU result back to the register file and reports it on a retire port.

## Interface
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural registers; x0 hardwired zero
- `i_clk`  in  1  single clock; everything is on the rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_valid`  in  1  decoded instruction present
- `o_ready`  out  1  stage accepts the instruction this cycle
- `i_rs1`, `i_rs2`, `i_rd`  in  5 each  register indices
- `i_imm`  in  XLEN  sign-extended immediate
- `i_pc`  in  XLEN  instruction PC
- `i_use_imm`  in  1  op2 = imm instead of rs2
- `i_use_pc`  in  1  op1 = pc instead of rs1
- `i_opsel`  in  4  ALU operation, passed through unchanged
- `o_op1`, `o_op2`  out  XLEN  registered operands to `main_alu`
- `o_opsel`  out  4  registered opsel to `main_alu`
- `i_aluout`  in  XLEN  `main_alu` result, valid the cycle after operands are presented
- `o_ret_valid`  out  1  retire strobe, one pulse per completed instruction
- `o_ret_rd`  out  5  retired destination
- `o_ret_data`  out  XLEN  retired result

## Operation
- Pipeline positions:
  - E1 holds the operand registers (`o_op1`, `o_op2`, `o_opsel`) plus `e1_valid` and `e1_rd`.
  - E2 holds `e2_valid` and `e2_rd` and corresponds to `i_aluout` being valid.
- Handshake: transfer occurs when `i_valid && o_ready`. `o_ready` is combinational and equals `!hazard`. It does not depend on `i_valid` except through hazard detection.
- Hazard (RAW on E1): the source is used, `rs != 0`, `e1_valid`, and `rs == e1_rd`.
  - rs1 is used iff `!i_use_pc`. rs2 is used iff `!i_use_imm`.
- Operand source priority for each used rs:
  - `rs == 0` → 0.
  - Else `e2_valid && rs == e2_rd && e2_rd != 0` → `i_aluout` (forward).
  - Else the register-file read (combinational).
- Every edge:
  - E2 ← E1.
  - On transfer, E1 ← new instruction.
  - Otherwise E1 becomes a bubble (`e1_valid=0`); the operand registers hold their old values.
- Writeback: at the edge where `e2_valid` is 1, `regfile[e2_rd] ← i_aluout` if `e2_rd != 0`. Writes to x0 are dropped but still retire.
- Retire: `o_ret_valid`, `o_ret_rd`, and `o_ret_data` are registered from the E2 writeback. They are valid the cycle after writeback and pulse for one cycle.
- Simultaneous events:
  - A regfile write and a read of the same index in the same cycle return the forwarded `i_aluout`. The forwarding priority covers this case, so the regfile needs no write-through.
  - rs1 == rs2 == hazard index produces a single stall cycle.

## Timing
- Transfer at edge T → `o_op*` valid during T+1 → `i_aluout` valid during T+2 → regfile updated at edge T+3 → `o_ret_valid` high during T+3.
- Dependent instruction at T+1: `o_ready=0` for exactly one cycle, then it issues at T+2 with the forwarded value.
- Dependent instruction at T+2 or later: no stall.
- Throughput is 1 instruction/cycle when there is no hazard.
- Reset (async, any time):
  - `e1_valid`, `e2_valid`, `o_ret_valid` → 0.
  - `o_op1`, `o_op2`, `o_ret_data` → 0; `o_opsel`, `o_ret_rd` → 0.
  - All regfile entries → 0.
  - In-flight instructions are discarded with no writeback.
- `o_ready` is 1 out of reset.

## Structure
- Shared header `rv_defs.vh`: `XLEN`, `REG_ADDR_W=5`, `OPSEL_W=4`, and the ALU opsel constants (`ALU_ADD=4'h0`, …) shared with `main_alu`.
- Sub-module `alu_regfile`: 2 combinational read ports, 1 synchronous write port, x0 reads 0, async reset to 0.
- Hazard detection, forwarding muxes, and E1/E2/retire registers live in the top. Expected size is about 200 lines of RTL.

## Test plan
- Reset then idle:
  - All outputs are 0 and `o_ready=1`.
  - Assert `i_rst` mid-stream with E1 and E2 full → no `o_ret_valid` pulse follows.
- `x0`: issue ADD rd=0, imm=5, then ADD rs1=0, use_imm, imm=7, rd=1 → `o_op1=0`; retires x0=5 (dropped) and x1=7.
- Back-to-back RAW: `x1←0+10` then `x2←x1+imm 1` → one-cycle `o_ready=0`; the second instruction issues with `o_op1=10`; retires x2=11.
- Distance-2 forward: `x1←3`, an unrelated instruction, then `x3←x1+x1` → no stall; `o_op1=o_op2=3`; retires x3=6.
- Operand select:
  - `use_pc`, pc=0x100, imm=4 → `o_op1=0x100`, `o_op2=4`.
  - A hazard on rs1 with `use_pc=1` → no stall.
- Stream of 16 independent ADDs at full rate → 16 retire pulses on 16 consecutive cycles, in order, with correct rd and data.
